oam_dma: RTL and testbench



---
 rtl/oam_dma.sv | 133 +++++++++++++
 tb/tb_oam_dma.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/oam_dma.sv
// OAM-style DMA bus master: copies LENGTH bytes from page {src,8'h00} to DEST_BASE, one byte per READ/WRITE pair.
// Optional dma_done pulse output is compiled in when OAM_DMA_DONE_EN is defined.
module oam_dma #(
  parameter int          LENGTH    = 160,
  parameter logic [15:0] DEST_BASE = 16'hFE00
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        dma_start,
  input  logic [7:0]  dma_src_hi,
  output logic        bus_req,
  input  logic        bus_gnt,
  output logic [15:0] addr_ext,
  output logic        mem_re,
  output logic        mem_we,
  inout  wire  [7:0]  data_ext,
  output logic        dma_busy
`ifdef OAM_DMA_DONE_EN
  ,
  output logic        dma_done
`endif
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_REQ   = 2'd1,
    ST_READ  = 2'd2,
    ST_WRITE = 2'd3
  } state_t;

  localparam logic [7:0] LAST_IDX = 8'(LENGTH - 1);

  state_t     state_q, state_d;
  logic [7:0] idx_q, idx_d;
  logic [7:0] src_q, src_d;
  logic [7:0] byte_q, byte_d;
  logic       last_write;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      idx_q   <= 8'h00;
      src_q   <= 8'h00;
      byte_q  <= 8'h00;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      src_q   <= src_d;
      byte_q  <= byte_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    src_d      = src_q;
    byte_d     = byte_q;
    last_write = 1'b0;
    bus_req    = 1'b0;
    dma_busy   = 1'b0;
    mem_re     = 1'b0;
    mem_we     = 1'b0;
    addr_ext   = 16'h0000;

    case (state_q)
      ST_IDLE: begin
        if (dma_start) begin
          src_d   = dma_src_hi;
          idx_d   = 8'h00;
          state_d = ST_REQ;
        end
      end
      ST_REQ: begin
        bus_req  = 1'b1;
        dma_busy = 1'b1;
        if (bus_gnt) state_d = ST_READ;
      end
      ST_READ: begin
        bus_req  = 1'b1;
        dma_busy = 1'b1;
        // Losing the grant drops the strobes in the same cycle; the byte is re-read after regrant.
        if (bus_gnt) begin
          mem_re   = 1'b1;
          addr_ext = {src_q, idx_q};
          byte_d   = data_ext;
          state_d  = ST_WRITE;
        end else begin
          state_d  = ST_REQ;
        end
      end
      ST_WRITE: begin
        bus_req  = 1'b1;
        dma_busy = 1'b1;
        if (bus_gnt) begin
          mem_we   = 1'b1;
          addr_ext = DEST_BASE + {8'h00, idx_q};
          if (idx_q == LAST_IDX) begin
            last_write = 1'b1;
            state_d    = ST_IDLE;
          end else begin
            idx_d   = idx_q + 8'd1;
            state_d = ST_READ;
          end
        end else begin
          state_d = ST_REQ;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // A start strobe mid-transfer supersedes everything, including completion.
    if (dma_start && (state_q != ST_IDLE)) begin
      src_d      = dma_src_hi;
      idx_d      = 8'h00;
      state_d    = ST_REQ;
      last_write = 1'b0;
    end
  end

  assign data_ext = mem_we ? byte_q : 8'bz;

`ifdef OAM_DMA_DONE_EN
  logic done_q;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) done_q <= 1'b0;
    else          done_q <= last_write;
  end

  assign dma_done = done_q;
`endif

endmodule

// File: tb/tb_oam_dma.sv
// Self-checking bench for oam_dma: memory model on the shared bus plus a reference copy of memory contents.
module tb_oam_dma;

  localparam int          LEN  = 160;
  localparam logic [15:0] DEST = 16'hFE00;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        dma_start;
  logic [7:0]  dma_src_hi;
  logic        bus_req;
  logic        bus_gnt;
  logic [15:0] addr_ext;
  logic        mem_re;
  logic        mem_we;
  wire  [7:0]  data_ext;
  logic        dma_busy;
`ifdef OAM_DMA_DONE_EN
  logic        dma_done;
`endif

  oam_dma #(.LENGTH(LEN), .DEST_BASE(DEST)) dut (
    .clock      (clock),
    .reset_n    (reset_n),
    .dma_start  (dma_start),
    .dma_src_hi (dma_src_hi),
    .bus_req    (bus_req),
    .bus_gnt    (bus_gnt),
    .addr_ext   (addr_ext),
    .mem_re     (mem_re),
    .mem_we     (mem_we),
    .data_ext   (data_ext),
    .dma_busy   (dma_busy)
`ifdef OAM_DMA_DONE_EN
    ,
    .dma_done   (dma_done)
`endif
  );

  always #5 clock = ~clock;

  // Shared byte memory: combinational read, write on rising edge; preload port for the bench.
  logic [7:0]  mem     [0:65535];
  logic [7:0]  ref_mem [0:65535];
  logic        pl_en;
  logic [15:0] pl_addr;
  logic [7:0]  pl_data;

  always @(posedge clock) begin
    if (pl_en)       mem[pl_addr]  <= pl_data;
    else if (mem_we) mem[addr_ext] <= data_ext;
  end

  assign data_ext = mem_re ? mem[addr_ext] : 8'bz;

  int         total = 0;
  int         bad   = 0;
  logic [7:0] cur_src;
  int         last_off;
  int         wr_count;
  int         done_cnt;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic fill(input logic [7:0] page, input bit rnd);
    logic [7:0] d;
    pl_en = 1'b1;
    for (int i = 0; i <= LEN; i++) begin
      d       = rnd ? 8'($urandom) : (8'(i) ^ 8'h5A);
      pl_addr = {page, 8'h00} + 16'(i);
      pl_data = d;
      ref_mem[{page, 8'h00} + 16'(i)] = d;
      @(posedge clock); #1;
    end
    pl_en = 1'b0;
  endtask

  // Rules that hold in every cycle, evaluated at the falling edge.
  task automatic cycle_check();
    logic [15:0] off;
    chk("strobe_excl", 32'(mem_re & mem_we), 32'd0);
    if (mem_re || mem_we) chk("gnt_gate", 32'({bus_req, bus_gnt}), 32'd3);
    else                  chk("addr_idle", 32'(addr_ext), 32'd0);
    if (mem_re) chk("rd_page", 32'(addr_ext[15:8]), 32'(cur_src));
    if (mem_we) begin
      off = addr_ext - DEST;
      chk("wr_range", 32'(off < 16'(LEN)), 32'd1);
      chk("wr_order", 32'(int'(off) <= last_off + 1), 32'd1);
      chk("wr_data", 32'(data_ext), 32'(ref_mem[{cur_src, off[7:0]}]));
      if (int'(off) > last_off) last_off = int'(off);
      wr_count++;
    end
`ifdef OAM_DMA_DONE_EN
    if (dma_done) done_cnt++;
`endif
  endtask

  task automatic check_dest(input logic [7:0] src);
    for (int i = 0; i < LEN; i++) begin
      chk("dest_byte", 32'(mem[DEST + 16'(i)]), 32'(ref_mem[{src, 8'(i)}]));
      ref_mem[DEST + 16'(i)] = ref_mem[{src, 8'(i)}];
    end
    chk("dest_past_end", 32'(mem[DEST + 16'(LEN)]), 32'(ref_mem[DEST + 16'(LEN)]));
  endtask

  // Runs one transfer. Grant is low for cycles [off_from, off_from+off_len) counted from the
  // first cycle after the start edge (or random if rnd_gnt). Returns start-to-idle cycle count.
  task automatic run_xfer(input logic [7:0] src, input int off_from, input int off_len,
                          input int restart_at, input logic [7:0] restart_src, input bit rnd_gnt,
                          input logic [15:0] reread_addr, input logic [15:0] rewrite_addr,
                          output int cycles);
    int c;
    dma_src_hi = src;
    dma_start  = 1'b1;
    @(negedge clock); cycle_check();
    @(posedge clock); #1;
    dma_start = 1'b0;
    cur_src   = src;
    last_off  = -1;
    wr_count  = 0;
    done_cnt  = 0;
    c = 0;
    while (1) begin
      if (c == restart_at) begin
        dma_start  = 1'b1;
        dma_src_hi = restart_src;
      end else if (dma_start) begin
        dma_start = 1'b0;
        cur_src   = restart_src;
        last_off  = -1;
        wr_count  = 0;
      end
      bus_gnt = rnd_gnt ? ($urandom_range(0, 3) != 0) : !(c >= off_from && c < off_from + off_len);
      @(negedge clock);
      cycle_check();
      if (!rnd_gnt && off_from == 0 && c < off_len)
        chk("wait_req", 32'({bus_req, mem_re, mem_we}), 32'd4);
      if (!rnd_gnt && off_from > 0) begin
        if (c == off_from)
          chk("drop_strobe", 32'({mem_re, mem_we, addr_ext}), 32'd0);
        if (c == off_from + off_len + 1)
          chk("reread", 32'({mem_re, addr_ext}), 32'({1'b1, reread_addr}));
        if (c == off_from + off_len + 2)
          chk("rewrite", 32'({mem_we, addr_ext}), 32'({1'b1, rewrite_addr}));
      end
      @(posedge clock); #1;
      c++;
      if (!dma_busy && !dma_start) break;
      if (c > 5000) begin
        chk("timeout", 32'd1, 32'd0);
        break;
      end
    end
    cycles  = c;
    bus_gnt = 1'b1;
    @(negedge clock);
    chk("idle_req", 32'({bus_req, dma_busy}), 32'd0);
`ifdef OAM_DMA_DONE_EN
    chk("done_early", 32'(done_cnt), 32'd0);
    chk("done_pulse", 32'(dma_done), 32'd1);
    @(negedge clock);
    chk("done_width", 32'(dma_done), 32'd0);
`endif
    $display("xfer src=%02h final_src=%02h cycles=%0d writes=%0d", src, cur_src, cycles, wr_count);
  endtask

  initial begin
    int cyc;
    logic [7:0] rpage;
    reset_n    = 1'b0;
    dma_start  = 1'b0;
    dma_src_hi = 8'h00;
    bus_gnt    = 1'b1;
    pl_en      = 1'b0;
    pl_addr    = 16'h0000;
    pl_data    = 8'h00;
    cur_src    = 8'h00;
    last_off   = -1;
    wr_count   = 0;
    done_cnt   = 0;

    @(negedge clock);
    chk("reset_outs", 32'({bus_req, dma_busy, mem_re, mem_we, addr_ext}), 32'd0);
`ifdef OAM_DMA_DONE_EN
    chk("reset_done", 32'(dma_done), 32'd0);
`endif
    @(posedge clock); #1;
    reset_n = 1'b1;

    fill(8'hC0, 1'b0);
    fill(8'hD0, 1'b1);
    fill(8'hFE, 1'b1);

    // Basic copy, grant held high.
    run_xfer(8'hC0, -1, 0, -1, 8'hC0, 1'b0, 16'h0, 16'h0, cyc);
    chk("basic_cycles", 32'(cyc), 32'd321);
    chk("basic_writes", 32'(wr_count), 32'(LEN));
    check_dest(8'hC0);

    // Grant withheld for 10 cycles after start.
    fill(8'hFE, 1'b1);
    run_xfer(8'hC0, 0, 10, -1, 8'hC0, 1'b0, 16'h0, 16'h0, cyc);
    chk("delay_cycles", 32'(cyc), 32'd331);
    chk("delay_writes", 32'(wr_count), 32'(LEN));
    check_dest(8'hC0);

    // Grant dropped for 5 cycles during byte 40's WRITE (cycle 2+2*40).
    fill(8'hFE, 1'b1);
    run_xfer(8'hC0, 82, 5, -1, 8'hC0, 1'b0, 16'hC028, DEST + 16'd40, cyc);
    chk("drop_cycles", 32'(cyc), 32'd328);
    check_dest(8'hC0);

    // Restart from page D0 during byte 80's READ (cycle 1+2*80).
    fill(8'hFE, 1'b1);
    run_xfer(8'hC0, -1, 0, 161, 8'hD0, 1'b0, 16'h0, 16'h0, cyc);
    chk("restart_cycles", 32'(cyc), 32'd162 + 32'd321);
    chk("restart_writes", 32'(wr_count), 32'(LEN));
    check_dest(8'hD0);

    // Random page contents and random grant pattern.
    rpage = 8'($urandom_range(8'h80, 8'hBF));
    fill(rpage, 1'b1);
    fill(8'hFE, 1'b1);
    run_xfer(rpage, -1, 0, -1, rpage, 1'b1, 16'h0, 16'h0, cyc);
    chk("rnd_min_cycles", 32'(cyc >= 321), 32'd1);
    check_dest(rpage);

    // Asynchronous reset during byte 100's WRITE (cycle 202).
    fill(8'hFE, 1'b1);
    dma_src_hi = 8'hC0;
    dma_start  = 1'b1;
    @(posedge clock); #1;
    dma_start = 1'b0;
    cur_src   = 8'hC0;
    last_off  = -1;
    done_cnt  = 0;
    for (int c = 0; c < 202; c++) begin
      @(negedge clock); cycle_check();
      @(posedge clock); #1;
    end
    chk("pre_reset_we", 32'({mem_we, addr_ext}), 32'({1'b1, DEST + 16'd100}));
    reset_n = 1'b0;
    #1;
    chk("async_reset_outs", 32'({bus_req, dma_busy, mem_re, mem_we, addr_ext}), 32'd0);
    @(posedge clock); @(posedge clock); #1;
    reset_n = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(negedge clock);
      cycle_check();
      chk("post_reset_idle", 32'({bus_req, dma_busy, mem_re, mem_we}), 32'd0);
    end
`ifdef OAM_DMA_DONE_EN
    chk("reset_no_done", 32'(done_cnt), 32'd0);
`endif
    chk("reset_byte99", 32'(mem[DEST + 16'd99]), 32'(ref_mem[16'hC063]));
    chk("reset_byte100", 32'(mem[DEST + 16'd100]), 32'(ref_mem[DEST + 16'd100]));
    $display("xfer src=c0 aborted by reset at byte 100");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
